// File: rtl/sync_to_async_src.sv
`timescale 1ns/1ps
// Clocked source stage for a 2-phase bundled-data micropipeline.
// Words from a valid/ready producer are buffered in a small FIFO, presented
// on data_out one cycle before each req_out transition, and retired when the
// resynchronised ack_in matches req_out again.
module sync_to_async_src #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          REQ_RST_VAL = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         req_out,
  input  logic                         ack_in,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         proto_err
);

  localparam int unsigned  CW       = $clog2(DEPTH + 1);
  localparam int unsigned  PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT_ACK
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    req_q, req_d;
  logic                    err_q, err_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    ack_sync;
  logic                    push;
  logic                    pop;

  assign ack_sync = sync_q[SYNC_STAGES-1];
  // s_ready comes from registered occupancy, so a slot freed by a pop is
  // only offered to the producer on the following cycle.
  assign s_ready  = (count_q != FULL_CNT);
  assign push     = s_valid && s_ready;

  assign data_out  = data_q;
  assign req_out   = req_q;
  assign count     = count_q;
  assign busy      = (state_q != IDLE);
  assign proto_err = err_q;

  // Resynchronise the asynchronous acknowledge; resets to the idle req level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {SYNC_STAGES{REQ_RST_VAL}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in};
  end

  // FIFO storage; contents are only read while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  // Token handshake: load word, toggle req next cycle, wait for matching ack.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    pop     = 1'b0;
    // Outside WAIT_ACK the acknowledge must already match the request.
    err_d   = err_q | ((state_q != WAIT_ACK) && (ack_sync != req_q));
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          state_d = SETUP;
        end
      end
      SETUP: begin
        req_d   = ~req_q;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_sync == req_q) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            data_d  = mem_q[rd_ptr_q];
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State, handshake and FIFO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= REQ_RST_VAL;
      data_q   <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      data_q   <= data_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_sync_to_async_src.sv
`timescale 1ns/1ps
// Bench for sync_to_async_src: transaction-level model plus directed cases.
module tb_sync_to_async_src;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam bit RRV   = 1'b1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] data_out;
  logic          req_out;
  logic          ack_in;
  logic [CW-1:0] count;
  logic          busy;
  logic          proto_err;

  logic ack_r = RRV;
  logic ack_flip = 1'b0;
  logic ack_en = 1'b0;
  assign ack_in = ack_r ^ ack_flip;

  always #5 clk = ~clk;

  sync_to_async_src #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .SYNC_STAGES(SS),
    .REQ_RST_VAL(RRV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_out (data_out),
    .req_out  (req_out),
    .ack_in   (ack_in),
    .count    (count),
    .busy     (busy),
    .proto_err(proto_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream control stage: answers each req transition 3 ns later when enabled.
  always @(req_out or ack_en or rst or ack_flip) begin
    if (rst) begin
      ack_r = RRV;
    end else if (ack_en && ((ack_r ^ ack_flip) != req_out)) begin
      #3;
      if (!rst && ack_en) ack_r = req_out ^ ack_flip;
    end
  end

  // Reference model: a queue of pending words plus the token in flight.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_data;
  logic          m_req;
  logic          m_loaded;   // word presented, req edge still to come
  logic          m_waiting;  // req edge sent, ack outstanding
  logic          m_err;
  logic          ack_hist[$];
  logic          m_acks;
  logic          m_room;
  logic          m_free;

  task automatic model_reset();
    mq.delete();
    m_data = '0; m_req = RRV; m_loaded = 1'b0; m_waiting = 1'b0; m_err = 1'b0;
    ack_hist.delete();
    for (int i = 0; i < SS; i++) ack_hist.push_back(RRV);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        m_acks = ack_hist[SS-1];               // ack level as seen SS edges late
        m_room = (int'(mq.size()) < DEPTH);
        m_free = !m_loaded && (!m_waiting || (m_acks == m_req));
        if (!m_waiting && (m_acks != m_req)) m_err = 1'b1;
        if (m_loaded) begin
          m_req = ~m_req; m_loaded = 1'b0; m_waiting = 1'b1;
        end else if (m_free) begin
          m_waiting = 1'b0;
          if (mq.size() > 0) begin
            m_data = mq.pop_front();
            m_loaded = 1'b1;
          end
        end
        if (s_valid && m_room) mq.push_back(s_data);
        ack_hist.push_front(ack_in);
        void'(ack_hist.pop_back());
      end
    end
  end

  // Compare every cycle outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("data_out",  32'(data_out),  32'(m_data));
        check("req_out",   32'(req_out),   32'(m_req));
        check("count",     32'(count),     32'(mq.size()));
        check("s_ready",   32'(s_ready),   32'(int'(mq.size()) < DEPTH));
        check("busy",      32'(busy),      32'(m_loaded || m_waiting));
        check("proto_err", 32'(proto_err), 32'(m_err));
      end
    end
  end

  // Log of data_out captured at each req_out transition.
  logic [DW-1:0] log_q[$];
  logic          prev_req = RRV;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (req_out != prev_req)) log_q.push_back(data_out);
      prev_req = req_out;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1; ack_flip = 1'b0; s_valid = 1'b0;
    #1;
    check("rst_req_out",   32'(req_out),   32'(RRV));
    check("rst_count",     32'(count),     0);
    check("rst_s_ready",   32'(s_ready),   1);
    check("rst_busy",      32'(busy),      0);
    check("rst_proto_err", 32'(proto_err), 0);
    check("rst_data_out",  32'(data_out),  0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((busy || count != '0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(busy || count != '0), 0);
  endtask

  int mark;
  logic [DW-1:0] exp_seq[$];

  initial begin
    // Reset state.
    do_reset();

    // Single token 0xA5.
    @(negedge clk); ack_en = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
    mark = log_q.size();
    @(posedge clk); #1;                        // edge N: pushed
    check("t1_count_N", 32'(count), 1);
    @(negedge clk); s_valid = 1'b0;
    @(posedge clk); #1;                        // edge N+1
    check("t1_data_N1", 32'(data_out), 32'hA5);
    check("t1_req_N1",  32'(req_out), 1);
    @(posedge clk); #1;                        // edge N+2
    check("t1_req_N2",  32'(req_out), 0);
    check("t1_busy_N2", 32'(busy), 1);
    wait_drain(20);
    check("t1_req_end", 32'(req_out), 0);
    check("t1_log",     32'(log_q.size() - mark), 1);

    // Backpressure: five words with acks stalled.
    @(negedge clk); ack_en = 1'b0;
    mark = log_q.size();
    s_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      s_data = 8'(i);
      @(negedge clk);
    end
    s_data = 8'h66;                            // offered while full, must be refused
    @(negedge clk); s_valid = 1'b0;
    check("t2_count_full", 32'(count), 4);
    check("t2_s_ready",    32'(s_ready), 0);
    check("t2_inflight",   32'(data_out), 1);
    check("t2_toggles0",   32'(log_q.size() - mark), 1);
    ack_en = 1'b1;
    wait_drain(100);
    check("t2_toggles", 32'(log_q.size() - mark), 5);
    for (int i = 0; i < 5; i++)
      if (mark + i < log_q.size()) check("t2_order", 32'(log_q[mark+i]), 32'(i + 1));

    // Push in the same cycle as a WAIT_ACK->SETUP pop.
    @(negedge clk); ack_en = 1'b0;
    mark = log_q.size();
    s_valid = 1'b1; s_data = 8'h11;
    @(negedge clk); s_data = 8'h22;
    @(negedge clk); s_data = 8'h33;
    @(negedge clk); s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_count_pre", 32'(count), 2);
    ack_en = 1'b1;                             // E0: ack settles before next edge
    repeat (2) @(negedge clk);
    s_valid = 1'b1; s_data = 8'h44;
    @(posedge clk); #1;                        // completion edge: pop 0x22, push 0x44
    check("t3_count_same", 32'(count), 2);
    check("t3_data",       32'(data_out), 32'h22);
    @(negedge clk); s_valid = 1'b0;
    wait_drain(100);
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    check("t3_toggles", 32'(log_q.size() - mark), 4);
    for (int i = 0; i < 4; i++)
      if (mark + i < log_q.size()) check("t3_order", 32'(log_q[mark+i]), 32'(exp_seq[i]));

    // Spurious acknowledge while idle.
    @(negedge clk); ack_en = 1'b0;
    repeat (2) @(negedge clk);
    ack_flip = 1'b1;
    check("t4_err_before", 32'(proto_err), 0);
    for (int n = 0; n < 8 && !proto_err; n++) @(negedge clk);
    check("t4_err_set", 32'(proto_err), 1);
    repeat (5) @(negedge clk);
    check("t4_err_sticky", 32'(proto_err), 1);
    ack_en = 1'b1;
    mark = log_q.size();
    s_valid = 1'b1; s_data = 8'h3C;
    @(negedge clk); s_valid = 1'b0;
    wait_drain(40);
    check("t4_token", 32'(log_q.size() - mark), 1);
    if (log_q.size() > mark) check("t4_data", 32'(log_q[mark]), 32'h3C);
    check("t4_err_kept", 32'(proto_err), 1);

    // Reset while a token is in flight with three words queued.
    do_reset();
    @(negedge clk); ack_en = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 8'(8'hC1 + i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_count_pre", 32'(count), 3);
    check("t5_busy_pre",  32'(busy), 1);
    do_reset();
    mark = log_q.size();
    @(negedge clk); ack_en = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_no_toggle", 32'(log_q.size() - mark), 0);
    check("t5_req",       32'(req_out), 32'(RRV));
    check("t5_busy",      32'(busy), 0);
    check("t5_count",     32'(count), 0);

    // Randomised traffic with random ack stalls.
    do_reset();
    @(negedge clk); ack_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      s_valid = ($urandom_range(0, 99) < 55);
      s_data  = 8'($urandom);
      if ($urandom_range(0, 99) < 8) ack_en = ~ack_en;
    end
    s_valid = 1'b0; ack_en = 1'b1;
    wait_drain(200);
    check("rand_err", 32'(proto_err), 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
